// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake FIFO slice.
package handshake_pkg;

  // Pointer width: address bits plus one wrap bit that tells full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/handshake_if.sv
// One valid/ready/data channel; the source drives valid/data, the sink drives ready.
interface handshake_if #(
  parameter int DATA_BITS = 8
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/handshake_fifo_ctrl.sv
// Pointer bookkeeping for the FIFO: push/pop decode, wrap-bit pointers,
// registered full/empty handshake flags, level and head-register load selects.
module handshake_fifo_ctrl
  import handshake_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ptr_w(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              m_ready,
  output logic              s_ready,
  output logic              m_valid,
  output logic              push,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_next_addr,
  output logic [LVL_W-1:0]  level,
  output logic              head_from_input,
  output logic              head_from_ram
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_s_ready;
  logic             r_m_valid;

  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [LVL_W-1:0] w_level;
  logic             w_push;
  logic             w_pop;
  logic             w_full_next;
  logic             w_empty_next;

  // Transfers only happen against the registered flags, so no input reaches
  // an output combinationally.
  assign w_push = s_valid & r_s_ready;
  assign w_pop  = r_m_valid & m_ready;

  // DEPTH is a power of two, so a plain binary increment wraps the address
  // bits DEPTH-1 -> 0 and toggles the wrap bit for free.
  assign w_rd_ptr_inc  = r_rd_ptr + PTR_W'(1);
  assign w_wr_ptr_next = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
  assign w_rd_ptr_next = w_pop  ? w_rd_ptr_inc         : r_rd_ptr;

  assign w_empty_next = (w_wr_ptr_next == w_rd_ptr_next);
  assign w_full_next  = (w_wr_ptr_next[ADDR_W-1:0] == w_rd_ptr_next[ADDR_W-1:0]) &&
                        (w_wr_ptr_next[PTR_W-1]    != w_rd_ptr_next[PTR_W-1]);

  // Modular pointer difference is the occupancy, 0..DEPTH.
  assign w_level = LVL_W'(r_wr_ptr - r_rd_ptr);

  // Head register reload: an incoming beat becomes the head when the FIFO is
  // empty, or when the only stored beat leaves on the same edge; otherwise a
  // pop exposes the next stored entry.
  assign head_from_input = w_push & ((w_level == '0) | (w_pop & (w_level == LVL_W'(1))));
  assign head_from_ram   = w_pop & (w_level > LVL_W'(1));

  // Pointer and flag registers.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_s_ready <= !w_full_next;
      r_m_valid <= !w_empty_next;
    end
  end

  assign s_ready      = r_s_ready;
  assign m_valid      = r_m_valid;
  assign push         = w_push;
  assign wr_addr      = r_wr_ptr[ADDR_W-1:0];
  assign rd_next_addr = w_rd_ptr_inc[ADDR_W-1:0];
  assign level        = w_level;

endmodule

// File: rtl/handshake_fifo.sv
// First-word-fall-through valid/ready FIFO, registered in both directions.
// Storage array plus a registered copy of the head entry driving m_data.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter  int DATA_BITS = 8,
  parameter  int DEPTH     = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [LVL_W-1:0]     level
);

  // Pointer arithmetic relies on a power-of-two depth of at least two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("handshake_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] r_m_data;
  logic [DATA_BITS-1:0] w_head_next;
  logic                 w_push;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [ADDR_W-1:0]    w_rd_next_addr;
  logic                 w_head_from_input;
  logic                 w_head_from_ram;

  handshake_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .m_ready         (m_ready),
    .s_ready         (s_ready),
    .m_valid         (m_valid),
    .push            (w_push),
    .wr_addr         (w_wr_addr),
    .rd_next_addr    (w_rd_next_addr),
    .level           (level),
    .head_from_input (w_head_from_input),
    .head_from_ram   (w_head_from_ram)
  );

  // Storage write on every accepted beat.
  // NOTE: the array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_addr] <= s_data;
    end
  end

  // Next head value: fresh input, next stored entry, or hold.
  // NOTE: default assignment first, so no path leaves the value unassigned and no latch is inferred.
  always_comb begin
    w_head_next = r_m_data;
    if (w_head_from_input) begin
      w_head_next = s_data;
    end else if (w_head_from_ram) begin
      w_head_next = r_mem[w_rd_next_addr];
    end
  end

  // Head register; holds while the downstream stalls or the FIFO is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_data <= '0;
    end else begin
      r_m_data <= w_head_next;
    end
  end

  assign m_data = r_m_data;

endmodule

// File: tb/tb_handshake_fifo.sv
module tb_handshake_fifo;
  localparam int DATA_BITS = 8;
  localparam int DEPTH     = 4;
  localparam int LVL_W     = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [LVL_W-1:0] level;

  handshake_if #(.DATA_BITS(DATA_BITS)) s_if ();
  handshake_if #(.DATA_BITS(DATA_BITS)) m_if ();

  handshake_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_if.valid),
    .s_ready (s_if.ready),
    .s_data  (s_if.data),
    .m_valid (m_if.valid),
    .m_ready (m_if.ready),
    .m_data  (m_if.data),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: beats queued at handshake time, compared when they leave.
  logic [DATA_BITS-1:0] sb_q[$];
  logic                 first_after_rst = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      first_after_rst = 1'b1;
    end else begin
      check("mon_level", 32'(level), 32'(sb_q.size()));
      check("mon_m_valid", 32'(m_if.valid), 32'(sb_q.size() != 0));
      if (!first_after_rst)
        check("mon_s_ready", 32'(s_if.ready), 32'(sb_q.size() < DEPTH));
      first_after_rst = 1'b0;
      if (m_if.valid && m_if.ready && sb_q.size() != 0) begin
        check("sb_data", 32'(m_if.data), 32'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      if (s_if.valid && s_if.ready) sb_q.push_back(s_if.data);
    end
  end

  typedef struct {
    logic                 sv;
    logic [DATA_BITS-1:0] sd;
    logic                 mr;
    logic                 e_sr;
    logic                 e_mv;
    logic [DATA_BITS-1:0] e_md;
    logic [LVL_W-1:0]     e_lvl;
  } vec_t;

  vec_t vecs[18];

  task automatic drain(input string name);
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    logic did_push;

    // inputs ---------------------------------- expected outputs before the edge
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    vecs[2]  = '{1'b1, 8'hC4, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC4, 3'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC4, 3'd0};
    vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'hC4, 3'd0};
    vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1};
    vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
    vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
    vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
    vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
    vecs[11] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 3'd4};
    vecs[12] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h02, 3'd3};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 3'd4};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3'd3};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 3'd1};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 3'd0};

    // Reset held for 10 cycles with the upstream pushing.
    rst        = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'hFF;
    m_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_s_ready", 32'(s_if.ready), 32'd0);
      check("rst_m_valid", 32'(m_if.valid), 32'd0);
      check("rst_level",   32'(level),      32'd0);
      check("rst_m_data",  32'(m_if.data),  32'd0);
    end
    @(posedge clk); #1;
    rst        = 1'b1;
    s_if.valid = 1'b0;

    // Pass-through, fill to full, stall release, drain.
    for (int i = 0; i < 18; i++) begin
      s_if.valid = vecs[i].sv;
      s_if.data  = vecs[i].sd;
      m_if.ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d_s_ready", i), 32'(s_if.ready), 32'(vecs[i].e_sr));
      check($sformatf("vec%0d_m_valid", i), 32'(m_if.valid), 32'(vecs[i].e_mv));
      check($sformatf("vec%0d_m_data",  i), 32'(m_if.data),  32'(vecs[i].e_md));
      check($sformatf("vec%0d_level",   i), 32'(level),      32'(vecs[i].e_lvl));
      @(posedge clk); #1;
    end

    // Concurrent push and pop at level 2.
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'h10;
    @(posedge clk); #1;
    s_if.data  = 8'h11;
    @(posedge clk); #1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_if.data = 8'(8'h12 + i);
      @(negedge clk);
      check("conc_level", 32'(level), 32'd2);
      @(posedge clk); #1;
    end
    drain("conc_drain");

    // Random back-pressure with 200 beats; upstream holds each beat until taken.
    sent       = 0;
    cyc        = 0;
    s_if.valid = 1'b0;
    while ((sent < 200 || s_if.valid || sb_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      did_push = s_if.valid && s_if.ready;
      @(posedge clk); #1;
      cyc++;
      if (did_push) sent++;
      if (!s_if.valid || did_push) begin
        if (sent < 200 && $urandom_range(3) != 0) begin
          s_if.valid = 1'b1;
          s_if.data  = 8'($urandom);
        end else begin
          s_if.valid = 1'b0;
        end
      end
      m_if.ready = 1'($urandom_range(1));
    end
    check("rand_in_budget", 32'(cyc < 5000), 32'd1);
    check("rand_beats", 32'(sent), 32'd200);
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;

    // Reset in the middle of operation at level 3.
    s_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.data = 8'(8'h31 + i);
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    @(negedge clk);
    check("mid_level_before", 32'(level), 32'd3);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_if.valid), 32'd0);
    check("mid_rst_level",   32'(level),      32'd0);
    check("mid_rst_s_ready", 32'(s_if.ready), 32'd0);
    check("mid_rst_m_data",  32'(m_if.data),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_level",   32'(level),      32'd0);
    check("post_rst_m_valid", 32'(m_if.valid), 32'd0);
    @(posedge clk); #1;
    s_if.valid = 1'b1;
    s_if.data  = 8'h77;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_if.ready), 32'd1);
    @(posedge clk); #1;
    s_if.valid = 1'b0;
    @(negedge clk);
    check("post_rst_new_valid", 32'(m_if.valid), 32'd1);
    check("post_rst_new_data",  32'(m_if.data),  32'h77);
    check("post_rst_new_level", 32'(level),      32'd1);
    @(posedge clk); #1;
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
